// File: rtl/core_pipe_fetch.sv
// core_pipe_fetch: instruction fetch front end with a small prefetch FIFO.
//
// A three-state fetch FSM (idle / request / wait) issues one word-aligned read at a time to
// a shared instruction RAM port. Each response is pushed with its address into a FIFO that
// feeds decode. A redirect from execute reloads the fetch PC, flushes the FIFO and discards
// any response still in flight.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   redirect_valid/pc   control-flow change from execute
//   mem_hold            data side owns the RAM port; suppresses new requests
//   ram_req/addr        read request (held stable until ram_gnt)
//   ram_gnt             request accepted
//   ram_rvalid/rdata    read response
//   id_valid/ready      FIFO head handshake to decode
//   id_pc/instr         oldest FIFO entry
//   fifo_count          occupied FIFO entries
module core_pipe_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             mem_hold,
  output logic             ram_req,
  output logic [31:0]      ram_addr,
  input  logic             ram_gnt,
  input  logic             ram_rvalid,
  input  logic [31:0]      ram_rdata,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_instr,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic        ram_req_q, ram_req_d;
  logic        kill_q, kill_d;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  logic [31:0] redirect_tgt;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        unused_redirect_lsbs;

  assign redirect_tgt         = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign fifo_full            = (count_q == CNT_W'(DEPTH));
  assign pop                  = (count_q != '0) && id_ready;

  // Fetch FSM. A request is only issued with a free FIFO slot, and only one is ever in
  // flight, so the response always has room even if decode stalls meanwhile.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    ram_addr_d = ram_addr_q;
    ram_req_d  = ram_req_q;
    kill_d     = kill_q;
    push       = 1'b0;
    case (state_q)
      StIdle: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_tgt;
        end else if (!mem_hold && !fifo_full) begin
          state_d    = StReq;
          ram_req_d  = 1'b1;
          ram_addr_d = fetch_pc_q;
        end
      end
      StReq: begin
        // mem_hold is deliberately ignored here: an issued request is never withdrawn.
        if (ram_gnt) begin
          state_d    = StWait;
          ram_req_d  = 1'b0;
          fetch_pc_d = redirect_valid ? redirect_tgt : fetch_pc_q + 32'd4;
          kill_d     = redirect_valid;
        end else if (redirect_valid) begin
          state_d    = StIdle;
          ram_req_d  = 1'b0;
          fetch_pc_d = redirect_tgt;
        end
      end
      StWait: begin
        if (ram_rvalid) begin
          push    = !kill_q && !redirect_valid;
          kill_d  = 1'b0;
          state_d = StIdle;
          if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
          end
        end else if (redirect_valid) begin
          kill_d     = 1'b1;
          fetch_pc_d = redirect_tgt;
        end
      end
      default: begin
        state_d   = StIdle;
        ram_req_d = 1'b0;
        kill_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      ram_addr_q <= '0;
      ram_req_q  <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ram_addr_q <= ram_addr_d;
      ram_req_q  <= ram_req_d;
      kill_q     <= kill_d;
    end
  end

  // FIFO bookkeeping; a redirect flushes and wins over any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= ram_addr_q;
      instr_mem[wr_ptr_q] <= ram_rdata;
    end
  end

  assign ram_req    = ram_req_q;
  assign ram_addr   = ram_addr_q;
  assign fifo_count = count_q;
  assign id_valid   = (count_q != '0);
  assign id_pc      = pc_mem[rd_ptr_q];
  assign id_instr   = instr_mem[rd_ptr_q];

endmodule

// File: tb/tb_core_pipe_fetch.sv
module tb_core_pipe_fetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             redirect_valid = 1'b0;
  logic [31:0]      redirect_pc = '0;
  logic             mem_hold = 1'b0;
  logic             ram_req;
  logic [31:0]      ram_addr;
  logic             ram_gnt = 1'b0;
  logic             ram_rvalid = 1'b0;
  logic [31:0]      ram_rdata = '0;
  logic             id_valid;
  logic             id_ready = 1'b0;
  logic [31:0]      id_pc;
  logic [31:0]      id_instr;
  logic [CNT_W-1:0] fifo_count;

  core_pipe_fetch #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .mem_hold      (mem_hold),
    .ram_req       (ram_req),
    .ram_addr      (ram_addr),
    .ram_gnt       (ram_gnt),
    .ram_rvalid    (ram_rvalid),
    .ram_rdata     (ram_rdata),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_pc         (id_pc),
    .id_instr      (id_instr),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: the fetch is "requested", "in flight" or neither, and the
  // prefetch buffer is a queue of {pc, instr} records.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_req;
  bit          m_inflight;
  bit          m_kill;

  task automatic model_reset();
    m_q.delete();
    m_pc       = RESET_PC;
    m_addr     = '0;
    m_req      = 1'b0;
    m_inflight = 1'b0;
    m_kill     = 1'b0;
  endtask

  // Advance the reference across one rising edge using the currently driven inputs.
  task automatic model_edge();
    logic [31:0] tgt;
    int          occ;
    bit          got_data;
    tgt      = redirect_pc & 32'hFFFF_FFFC;
    occ      = m_q.size();
    got_data = 1'b0;
    if (m_req) begin
      if (ram_gnt) begin
        m_req      = 1'b0;
        m_inflight = 1'b1;
        m_kill     = redirect_valid;
        m_pc       = redirect_valid ? tgt : m_pc + 32'd4;
      end else if (redirect_valid) begin
        m_req = 1'b0;
        m_pc  = tgt;
      end
    end else if (m_inflight) begin
      if (ram_rvalid) begin
        got_data   = !m_kill && !redirect_valid;
        m_inflight = 1'b0;
        m_kill     = 1'b0;
        if (redirect_valid) m_pc = tgt;
      end else if (redirect_valid) begin
        m_kill = 1'b1;
        m_pc   = tgt;
      end
    end else begin
      if (redirect_valid) begin
        m_pc = tgt;
      end else if (!mem_hold && occ < DEPTH) begin
        m_req  = 1'b1;
        m_addr = m_pc;
      end
    end
    if (redirect_valid) begin
      m_q.delete();
    end else begin
      if (occ != 0 && id_ready) void'(m_q.pop_front());
      if (got_data) m_q.push_back('{pc: m_addr, ins: ram_rdata});
    end
  endtask

  task automatic compare_outputs();
    check_eq("ram_req", 32'(ram_req), 32'(m_req));
    check_eq("ram_addr", ram_addr, m_addr);
    check_eq("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    check_eq("id_valid", 32'(id_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check_eq("id_pc", id_pc, m_q[0].pc);
      check_eq("id_instr", id_instr, m_q[0].ins);
    end
  endtask

  // Called at posedge+1: drive, update the reference, clock, compare.
  task automatic step(input logic rd, input logic [31:0] rpc, input logic hold,
                      input logic gnt, input logic rv, input logic rdy);
    redirect_valid = rd;
    redirect_pc    = rpc;
    mem_hold       = hold;
    ram_gnt        = gnt;
    ram_rvalid     = rv;
    ram_rdata      = $urandom;
    id_ready       = rdy;
    #1;
    model_edge();
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, 32'(ram_req), 32'd0);
    check_eq({tag, "_addr"}, ram_addr, 32'd0);
    check_eq({tag, "_valid"}, 32'(id_valid), 32'd0);
    check_eq({tag, "_count"}, 32'(fifo_count), 32'd0);
  endtask

  // Reset with responses and grants toggling underneath; all must be ignored.
  task automatic do_reset(input string tag);
    rst_n      = 1'b0;
    ram_gnt    = 1'b1;
    ram_rvalid = 1'b1;
    ram_rdata  = $urandom;
    #1;
    check_reset_outputs(tag);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs(tag);
    rst_n = 1'b1;
  endtask

  task automatic run_until_inflight(input string tag);
    for (int i = 0; i < 40 && !m_inflight; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq({tag, "_inflight_bound"}, 32'(m_inflight), 32'd1);
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset("rst");

    // First edge after release issues RESET_PC; full-speed streaming.
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("first_req", 32'(ram_req), 32'd1);
    check_eq("first_addr", ram_addr, RESET_PC);
    repeat (20) step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Decode stalled: FIFO fills to DEPTH and requests stop.
    repeat (30) step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("full_count", 32'(fifo_count), DEPTH);
    check_eq("full_no_req", 32'(ram_req), 32'd0);
    repeat (8) step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Redirect while a response is pending.
    run_until_inflight("redir");
    step(1'b1, 32'h0000_0103, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("redir_flush", 32'(fifo_count), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("redir_drop", 32'(id_valid), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("redir_addr", ram_addr, 32'h0000_0100);

    // Three buffered entries, then redirect with a same-cycle pop and response.
    for (int i = 0; i < 60 && m_q.size() != 3; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("fill3_bound", 32'(m_q.size()), 32'd3);
    for (int i = 0; i < 40 && !m_inflight; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0000_2000, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("combo_count", 32'(fifo_count), 32'd0);
    check_eq("combo_valid", 32'(id_valid), 32'd0);

    // Held off in idle, then hold raised during an outstanding request.
    repeat (5) begin
      step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
      check_eq("hold_idle", 32'(ram_req), 32'd0);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("hold_req", 32'(ram_req), 32'd1);
    end
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Address wrap at the top of memory.
    step(1'b1, 32'hFFFF_FFF6, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (12) step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of a pending read.
    run_until_inflight("midrst");
    @(negedge clk);
    do_reset("midrst");
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("restart_addr", ram_addr, RESET_PC);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step($urandom_range(0, 15) == 0, rpc, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/core_pipe_fetch.md
CORE_PIPE_FETCH -- requirements
Module: core_pipe_fetch

Interface
REQ-001 Parameter: DEPTH, 4, prefetch FIFO entries (power of two, >=2).
REQ-002 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter: CNT_W, $clog2(DEPTH+1), width of fifo_count.
REQ-004 The block SHALL provide the following ports, one per line:
  clk  in  1  clock, all state on rising edge
  rst_n  in  1  reset, asynchronous, active-low
  redirect_valid  in  1  control-flow change from execute
  redirect_pc  in  32  new fetch address
  mem_hold  in  1  data-side load/store owns RAM port; no new fetch request
  ram_req  out  1  instruction read request
  ram_addr  out  32  request address, word aligned
  ram_gnt  in  1  request accepted this cycle
  ram_rvalid  in  1  read data valid
  ram_rdata  in  32  read data
  id_valid  out  1  FIFO head valid to decode
  id_ready  in  1  decode accepts head
  id_pc  out  32  PC of head entry
  id_instr  out  32  instruction of head entry
  fifo_count  out  CNT_W  occupied entries

Function
REQ-005 The block SHALL run a fetch FSM with states IDLE, REQ, WAIT, all transitions on clk rising edge.
REQ-006 IDLE->REQ SHALL occur when !mem_hold, !redirect_valid, fifo_count<DEPTH; ram_req=1 and ram_addr=fetch_pc registered on that edge.
REQ-007 In REQ, ram_req and ram_addr SHALL stay constant until ram_gnt=1; mem_hold rising in REQ SHALL NOT withdraw the request.
REQ-008 REQ with ram_gnt=1 SHALL go to WAIT, deassert ram_req and advance fetch_pc by 4 (32-bit wrap from 32'hFFFF_FFFC to 0).
REQ-009 WAIT with ram_rvalid=1 SHALL push {fetched address, ram_rdata} into the FIFO unless kill is set, clear kill, and go to IDLE.
REQ-010 At most one request SHALL be outstanding; ram_rvalid outside WAIT SHALL be ignored.
REQ-011 redirect_valid SHALL set fetch_pc to {redirect_pc[31:2],2'b00} and empty the FIFO on the same edge.
REQ-012 Redirect in REQ without same-cycle ram_gnt SHALL drop the request (ram_req=0 next cycle) and go to IDLE.
REQ-013 Redirect in WAIT, or in REQ with same-cycle ram_gnt, SHALL set kill so the pending response is discarded.
REQ-014 Redirect coinciding with ram_rvalid in WAIT SHALL discard that data.
REQ-015 id_valid SHALL equal (fifo_count!=0); id_pc/id_instr SHALL show the oldest entry.
REQ-016 id_valid&id_ready SHALL pop one entry; simultaneous push and pop SHALL keep fifo_count unchanged.
REQ-017 Redirect SHALL override a same-cycle pop and push: fifo_count=0 next cycle.
REQ-018 FIFO SHALL never overflow: requests issue only with a free slot reserved for the response.
REQ-019 Minimum latency: ram_gnt in first REQ cycle, ram_rvalid next cycle -> id_valid=1 the cycle after ram_rvalid.
REQ-020 FIFO pointers SHALL wrap modulo DEPTH; full at fifo_count==DEPTH, empty at 0.

Reset
REQ-021 While rst_n=0: state=IDLE, fetch_pc=RESET_PC, ram_req=0, ram_addr=0, kill=0, fifo_count=0, id_valid=0.
REQ-022 Reset asserted mid-transaction SHALL abandon it; responses arriving during reset SHALL be ignored.
REQ-023 First ram_req SHALL assert on the first edge after rst_n release with mem_hold=0.

Verification
REQ-024 Reset release, mem_hold=0, ram_gnt always 1, rvalid one cycle after gnt, id_ready=1 -> id_pc sequence 0,4,8,... with matching ram_rdata.
REQ-025 id_ready=0, DEPTH=4 -> exactly 4 entries, fifo_count=4, ram_req stays 0 until a pop.
REQ-026 Redirect to 32'h0000_0103 while in WAIT -> pending response dropped, fifo_count=0, next ram_addr=32'h0000_0100.
REQ-027 mem_hold=1 in IDLE for 5 cycles -> ram_req=0 those cycles; mem_hold asserted in REQ -> request held until ram_gnt.
REQ-028 Redirect with same-cycle pop and rvalid, FIFO holding 3 entries -> fifo_count=0, id_valid=0 next cycle.
REQ-029 rst_n pulsed low in WAIT -> all outputs at reset values; fetch restarts at RESET_PC.
